// File: rtl/stream_demux_1n_pkg.sv
// rtl/stream_demux_1n_pkg.sv - shared constants and helpers for the 1:N stream demux
package stream_demux_1n_pkg;

  localparam int MIN_CHANNELS = 2;
  localparam int MAX_CHANNELS = 16;
  localparam int DROP_CNT_W   = 8;

  function automatic int sel_width(input int channels);
    return (channels <= 2) ? 1 : $clog2(channels);
  endfunction

  function automatic bit channels_ok(input int channels);
    return (channels >= MIN_CHANNELS) && (channels <= MAX_CHANNELS);
  endfunction

endpackage

// File: rtl/stream_demux_1n_if.sv
// rtl/stream_demux_1n_if.sv - input stream plus per-channel output streams of the demux
interface stream_demux_1n_if
  import stream_demux_1n_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = sel_width(CHANNELS)
);

  logic                      s_valid;
  logic                      s_ready;
  logic [WIDTH-1:0]          s_data;
  logic [SEL_W-1:0]          s_sel;
  logic                      s_bcast;
  logic [CHANNELS-1:0]       m_valid;
  logic [CHANNELS-1:0]       m_ready;
  logic [CHANNELS*WIDTH-1:0] m_data;

  modport master (
    output s_valid, s_data, s_sel, s_bcast, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, s_sel, s_bcast, m_ready,
    output s_ready, m_valid, m_data
  );

endinterface

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry output holding register for a single demux channel
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             m_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             free
);

  // Free when empty or draining this cycle, so drain and refill can overlap.
  assign free = ~m_valid | m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= data_in;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux_1n.sv
// rtl/stream_demux_1n.sv - registered 1:N stream demux with broadcast and bad-select accounting
module stream_demux_1n
  import stream_demux_1n_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = sel_width(CHANNELS),
  parameter int CNT_W    = DROP_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  stream_demux_1n_if.slave bus,
  output logic             err_sel,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (!channels_ok(CHANNELS)) begin : g_bad_channels
    $error("stream_demux_1n: CHANNELS out of range");
  end

  logic [CHANNELS-1:0]       free;
  logic [CHANNELS-1:0]       sel_hit;
  logic [CHANNELS-1:0]       load;
  logic [CHANNELS-1:0]       m_valid_w;
  logic [CHANNELS*WIDTH-1:0] m_data_w;
  logic                      sel_ok;
  logic                      accept;
  logic                      drop;

  // One-hot decode only covers real channels, so an out-of-range select decodes to zero.
  always_comb begin
    sel_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sel_hit[i] = (bus.s_sel == SEL_W'(i));
    end
  end

  assign sel_ok = |sel_hit;

  always_comb begin
    bus.s_ready = 1'b1;
    if (bus.s_bcast) begin
      bus.s_ready = &free;
    end else if (sel_ok) begin
      bus.s_ready = |(free & sel_hit);
    end
  end

  assign accept = bus.s_valid & bus.s_ready;
  assign drop   = accept & ~bus.s_bcast & ~sel_ok;
  assign load   = accept ? (bus.s_bcast ? {CHANNELS{1'b1}} : sel_hit) : '0;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load    (load[i]),
      .data_in (bus.s_data),
      .m_ready (bus.m_ready[i]),
      .m_valid (m_valid_w[i]),
      .m_data  (m_data_w[i*WIDTH +: WIDTH]),
      .free    (free[i])
    );
  end

  assign bus.m_valid = m_valid_w;
  assign bus.m_data  = m_data_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_sel  <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      err_sel <= 1'b1;
      if (drop_cnt != CNT_MAX) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule
